// File: rtl/bash_perm_ctrl.sv
// ============================================================================
// bash_perm_ctrl
// ----------------------------------------------------------------------------
// Control unit for the bash-f sponge permutation core. Sequences the prepare,
// start and round phases of one permutation per absorbed block, provides the
// round index used for round-constant selection, and buffers one start
// request that arrives mid-permutation so blocks can run back-to-back.
//
// Parameters
//   ROUNDS  total permutation rounds (ROUNDS/RPC >= 2)
//   RPC     rounds unrolled per work cycle (must divide ROUNDS)
//
// Ports
//   clk_i           clock, all state changes on the rising edge
//   rst_ni          synchronous active-low reset
//   prep_active_i   request: load a fresh state (new message)
//   start_active_i  request: run one permutation on the current state
//   prep_o          prep request accepted; datapath loads its initial state
//   start_o         start request accepted; datapath absorbs its block
//   first_o         qualifies start_o for the first block after a prep
//   work_o          datapath applies RPC rounds this cycle
//   round_o         index of the first round applied this cycle (0 when idle)
//   active_o        permutation in progress (same as work_o)
//   rdy_o           a start request would be accepted or buffered now
//   done_o          one-cycle pulse after a permutation's final work cycle
//   pend_o          a start request is buffered
// ============================================================================
module bash_perm_ctrl #(
    parameter  int ROUNDS = 24,
    parameter  int RPC    = 1,
    localparam int ITER   = ROUNDS / RPC,
    localparam int CW     = $clog2(ITER),
    localparam int RW     = $clog2(ROUNDS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          prep_active_i,
    input  logic          start_active_i,
    output logic          prep_o,
    output logic          start_o,
    output logic          first_o,
    output logic          work_o,
    output logic [RW-1:0] round_o,
    output logic          active_o,
    output logic          rdy_o,
    output logic          done_o,
    output logic          pend_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_START = 3'd2,
        S_WORK  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] k;      // work-cycle index within the current permutation
    logic          pend;   // one buffered start request
    logic          done;   // completion pulse, registered

    logic last_work;
    assign last_work = (k == CW'(ITER - 1));

    // ------------------------------------------------------------------------
    // State, counter and flags
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            k     <= '0;
            pend  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (prep_active_i) state <= S_PREP;
                end
                S_PREP: begin
                    if (start_active_i) state <= S_START;
                end
                S_START: begin
                    // The START cycle is itself the first work cycle (k = 0),
                    // so the counter continues from 1 in WORK.
                    k     <= CW'(1);
                    pend  <= 1'b0;
                    state <= S_WORK;
                end
                S_WORK: begin
                    if (prep_active_i) begin
                        // Abort: the buffered start belongs to the old message.
                        pend  <= 1'b0;
                        state <= S_PREP;
                    end else begin
                        if (start_active_i) pend <= 1'b1;
                        if (last_work) begin
                            done  <= 1'b1;
                            state <= (pend || start_active_i) ? S_START : S_WAIT;
                        end else begin
                            k <= k + CW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (prep_active_i)       state <= S_PREP;
                    else if (start_active_i) state <= S_START;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Mealy outputs; everything is held low while reset is asserted
    // ------------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        prep_o  = 1'b0;
        start_o = 1'b0;
        first_o = 1'b0;
        work_o  = 1'b0;
        round_o = '0;
        rdy_o   = 1'b0;
        if (rst_ni) begin
            case (state)
                S_IDLE: begin
                    rdy_o  = prep_active_i;
                    prep_o = prep_active_i;
                end
                S_PREP: begin
                    rdy_o = 1'b1;
                    if (start_active_i) begin
                        start_o = 1'b1;
                        first_o = 1'b1;
                    end else begin
                        prep_o = prep_active_i;
                    end
                end
                S_START: begin
                    work_o = 1'b1;
                end
                S_WORK: begin
                    work_o  = 1'b1;
                    round_o = RW'(int'(k) * RPC);
                    rdy_o   = ~pend;
                    if (prep_active_i) begin
                        prep_o = 1'b1;
                    end else if (last_work && (pend || start_active_i)) begin
                        start_o = 1'b1;
                    end
                end
                S_WAIT: begin
                    rdy_o = 1'b1;
                    if (prep_active_i)       prep_o  = 1'b1;
                    else if (start_active_i) start_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign active_o = work_o;
    assign done_o   = rst_ni & done;
    assign pend_o   = rst_ni & pend;

endmodule

// File: tb/tb_bash_perm_ctrl.sv
// ============================================================================
// tb_bash_perm_ctrl
// ----------------------------------------------------------------------------
// Drives two controller instances (ROUNDS=24 with RPC=1 and RPC=4) from the
// same request inputs. Directed scenarios check timing against fixed cycle
// numbers; a randomized run compares every output of both instances against
// a cycle-level reference model that tracks "which work cycle are we in",
// "is a start buffered" and "what context are we waiting in".
// ============================================================================
module tb_bash_perm_ctrl;

    localparam int ROUNDS = 24;
    localparam int RW     = $clog2(ROUNDS);
    localparam int VW     = 8 + RW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic prep_i  = 1'b0;
    logic start_i = 1'b0;

    logic          prep_a, start_a, first_a, work_a, active_a, rdy_a, done_a, pend_a;
    logic [RW-1:0] round_a;
    logic          prep_b, start_b, first_b, work_b, active_b, rdy_b, done_b, pend_b;
    logic [RW-1:0] round_b;

    bash_perm_ctrl #(.ROUNDS(ROUNDS), .RPC(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .prep_active_i(prep_i), .start_active_i(start_i),
        .prep_o(prep_a), .start_o(start_a), .first_o(first_a), .work_o(work_a),
        .round_o(round_a), .active_o(active_a), .rdy_o(rdy_a),
        .done_o(done_a), .pend_o(pend_a)
    );

    bash_perm_ctrl #(.ROUNDS(ROUNDS), .RPC(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .prep_active_i(prep_i), .start_active_i(start_i),
        .prep_o(prep_b), .start_o(start_b), .first_o(first_b), .work_o(work_b),
        .round_o(round_b), .active_o(active_b), .rdy_o(rdy_b),
        .done_o(done_b), .pend_o(pend_b)
    );

    logic [VW-1:0] act_a, act_b;
    assign act_a = {prep_a, start_a, first_a, work_a, active_a, rdy_a, done_a, pend_a, round_a};
    assign act_b = {prep_b, start_b, first_b, work_b, active_b, rdy_b, done_b, pend_b, round_b};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ------------------------------------------------------------------------
    // Reference model. wc = index of the current work cycle (-1: not working),
    // ctx = 0 never prepared, 1 prepared/awaiting first block, 2 between blocks.
    // ------------------------------------------------------------------------
    int rpc_m[2] = '{1, 4};
    int wc[2]    = '{-1, -1};
    int ctx[2]   = '{0, 0};
    bit pnd[2]   = '{1'b0, 1'b0};
    bit dn[2]    = '{1'b0, 1'b0};
    int n_wc[2]  = '{-1, -1};
    int n_ctx[2] = '{0, 0};
    bit n_pnd[2] = '{1'b0, 1'b0};
    bit n_dn[2]  = '{1'b0, 1'b0};
    logic [VW-1:0] exp_v[2];

    task automatic model_eval(input int i);
        int iter;
        int e_round;
        bit e_prep, e_start, e_first, e_work, e_rdy, e_done, e_pend, np;
        iter    = ROUNDS / rpc_m[i];
        e_round = 0;
        e_prep  = 0; e_start = 0; e_first = 0; e_work = 0;
        e_rdy   = 0; e_done  = 0; e_pend  = 0;
        n_wc[i]  = wc[i];
        n_ctx[i] = ctx[i];
        n_pnd[i] = pnd[i];
        n_dn[i]  = 1'b0;
        if (!rst_n) begin
            n_wc[i]  = -1;
            n_ctx[i] = 0;
            n_pnd[i] = 1'b0;
        end else begin
            e_done = dn[i];
            e_pend = pnd[i];
            if (wc[i] >= 0) begin
                e_work  = 1;
                e_round = wc[i] * rpc_m[i];
                if (wc[i] == 0) begin
                    n_pnd[i] = 1'b0;
                    n_wc[i]  = 1;
                end else begin
                    e_rdy = !pnd[i];
                    if (prep_i) begin
                        e_prep   = 1;
                        n_pnd[i] = 1'b0;
                        n_wc[i]  = -1;
                        n_ctx[i] = 1;
                    end else begin
                        np       = pnd[i] | start_i;
                        n_pnd[i] = np;
                        if (wc[i] == iter - 1) begin
                            n_dn[i] = 1'b1;
                            if (np) begin
                                e_start = 1;
                                n_wc[i] = 0;
                            end else begin
                                n_wc[i]  = -1;
                                n_ctx[i] = 2;
                            end
                        end else begin
                            n_wc[i] = wc[i] + 1;
                        end
                    end
                end
            end else if (ctx[i] == 0) begin
                e_rdy = prep_i;
                if (prep_i) begin
                    e_prep   = 1;
                    n_ctx[i] = 1;
                end
            end else if (ctx[i] == 1) begin
                e_rdy = 1;
                if (start_i) begin
                    e_start = 1;
                    e_first = 1;
                    n_wc[i] = 0;
                end else begin
                    e_prep = prep_i;
                end
            end else begin
                e_rdy = 1;
                if (prep_i) begin
                    e_prep   = 1;
                    n_ctx[i] = 1;
                end else if (start_i) begin
                    e_start = 1;
                    n_wc[i] = 0;
                end
            end
        end
        exp_v[i] = {e_prep, e_start, e_first, e_work, e_work, e_rdy, e_done, e_pend, RW'(e_round)};
    endtask

    // One clock cycle: advance the model, drive inputs after the edge, then
    // evaluate expectations at the falling edge where outputs are settled.
    task automatic step(input bit p, input bit s, input bit r);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            wc[i]  = n_wc[i];
            ctx[i] = n_ctx[i];
            pnd[i] = n_pnd[i];
            dn[i]  = n_dn[i];
        end
        #1;
        prep_i  = p;
        start_i = s;
        rst_n   = r;
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_eval(i);
        cyc++;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        step(1, 1, 0);
        step(1, 1, 0);
        checks++;
        if (act_a !== '0 || act_b !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got a=%h b=%h want 0", act_a, act_b);
        end
        step(0, 0, 1);
        checks++;
        if (act_a !== '0 || act_b !== '0) begin
            failures++;
            $display("FAIL idle_quiet: got a=%h b=%h want 0", act_a, act_b);
        end
    endtask

    // prep at cycle 0, start at cycle 2; both instances run one permutation.
    task automatic test_single();
        logic          ew_a, ew_b;
        logic [RW-1:0] er_a, er_b;
        step(1, 0, 1);
        checks++;
        if (prep_a !== 1'b1 || rdy_a !== 1'b1 || work_a !== 1'b0) begin
            failures++;
            $display("FAIL single_prep: got prep=%b rdy=%b work=%b want 1 1 0", prep_a, rdy_a, work_a);
        end
        step(0, 0, 1);
        checks++;
        if (rdy_a !== 1'b1 || prep_a !== 1'b0 || start_a !== 1'b0) begin
            failures++;
            $display("FAIL single_in_prep: got rdy=%b prep=%b start=%b want 1 0 0", rdy_a, prep_a, start_a);
        end
        step(0, 1, 1);
        checks++;
        if (start_a !== 1'b1 || first_a !== 1'b1 || start_b !== 1'b1 || first_b !== 1'b1) begin
            failures++;
            $display("FAIL single_start: got a=%b%b b=%b%b want start,first=11", start_a, first_a, start_b, first_b);
        end
        for (int n = 3; n <= 28; n++) begin
            step(0, 0, 1);
            ew_a = (n <= 26);
            er_a = ew_a ? RW'(n - 3) : '0;
            ew_b = (n <= 8);
            er_b = ew_b ? RW'(4 * (n - 3)) : '0;
            checks++;
            if (work_a !== ew_a || active_a !== ew_a || round_a !== er_a || done_a !== (n == 27)) begin
                failures++;
                $display("FAIL single_rpc1 cycle %0d: got work=%b round=%0d done=%b want %b %0d %b",
                         n, work_a, round_a, done_a, ew_a, er_a, (n == 27));
            end
            checks++;
            if (work_b !== ew_b || round_b !== er_b || done_b !== (n == 9)) begin
                failures++;
                $display("FAIL single_rpc4 cycle %0d: got work=%b round=%0d done=%b want %b %0d %b",
                         n, work_b, round_b, done_b, ew_b, er_b, (n == 9));
            end
        end
        checks++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            failures++;
            $display("FAIL single_wait_rdy: got a=%b b=%b want 1 1", rdy_a, rdy_b);
        end
    endtask

    // Start buffered at the 5th work cycle, a second start ignored while
    // pending; exactly one extra permutation follows with no gap.
    task automatic test_back_to_back();
        step(0, 1, 1);
        checks++;
        if (start_a !== 1'b1 || first_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_start: got start=%b first=%b want 1 0", start_a, first_a);
        end
        for (int j = 0; j < 24; j++) begin
            step(0, (j == 4) || (j == 10), 1);
            checks++;
            if (work_a !== 1'b1 || round_a !== RW'(j)) begin
                failures++;
                $display("FAIL b2b_first_perm j=%0d: got work=%b round=%0d want 1 %0d", j, work_a, round_a, j);
            end
            if (j == 3) begin
                checks++;
                if (pend_a !== 1'b0 || rdy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_before_pend: got pend=%b rdy=%b want 0 1", pend_a, rdy_a);
                end
            end
            if (j == 5) begin
                checks++;
                if (pend_a !== 1'b1 || rdy_a !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_pend: got pend=%b rdy=%b want 1 0", pend_a, rdy_a);
                end
            end
            if (j == 23) begin
                checks++;
                if (start_a !== 1'b1 || first_a !== 1'b0 || done_a !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_handoff: got start=%b first=%b done=%b want 1 0 0", start_a, first_a, done_a);
                end
            end
        end
        for (int j = 0; j < 24; j++) begin
            step(0, 0, 1);
            checks++;
            if (work_a !== 1'b1 || round_a !== RW'(j) || done_a !== (j == 0) || start_a !== 1'b0) begin
                failures++;
                $display("FAIL b2b_second_perm j=%0d: got work=%b round=%0d done=%b start=%b",
                         j, work_a, round_a, done_a, start_a);
            end
            if (j == 1) begin
                checks++;
                if (pend_a !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_pend_cleared: got %b want 0", pend_a);
                end
            end
        end
        step(0, 0, 1);
        checks++;
        if (work_a !== 1'b0 || done_a !== 1'b1 || start_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_final_done: got work=%b done=%b start=%b want 0 1 0", work_a, done_a, start_a);
        end
        step(0, 0, 1);
        checks++;
        if (work_a !== 1'b0 || done_a !== 1'b0 || rdy_a !== 1'b1) begin
            failures++;
            $display("FAIL b2b_no_third: got work=%b done=%b rdy=%b want 0 0 1", work_a, done_a, rdy_a);
        end
    endtask

    // prep and start together at round 10 abort the permutation.
    task automatic test_abort();
        step(0, 1, 1);
        for (int j = 0; j <= 10; j++) begin
            step(j == 10, (j == 3) || (j == 10), 1);
            if (j == 10) begin
                checks++;
                if (prep_a !== 1'b1 || start_a !== 1'b0 || work_a !== 1'b1 || round_a !== RW'(10)) begin
                    failures++;
                    $display("FAIL abort_accept: got prep=%b start=%b work=%b round=%0d want 1 0 1 10",
                             prep_a, start_a, work_a, round_a);
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 1);
            checks++;
            if (work_a !== 1'b0 || prep_a !== 1'b0 || pend_a !== 1'b0 || done_a !== 1'b0 || rdy_a !== 1'b1) begin
                failures++;
                $display("FAIL abort_in_prep %0d: got work=%b prep=%b pend=%b done=%b rdy=%b want 0 0 0 0 1",
                         j, work_a, prep_a, pend_a, done_a, rdy_a);
            end
        end
        step(0, 1, 1);
        checks++;
        if (start_a !== 1'b1 || first_a !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart_first: got start=%b first=%b want 1 1", start_a, first_a);
        end
        for (int j = 0; j < 25; j++) step(0, 0, 1);
        checks++;
        if (done_a !== 1'b1 || work_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart_done: got done=%b work=%b want 1 0", done_a, work_a);
        end
    endtask

    // Reset pulse mid-work with a start buffered.
    task automatic test_reset_mid_work();
        step(0, 1, 1);
        for (int j = 0; j < 8; j++) step(0, j == 2, 1);
        checks++;
        if (pend_a !== 1'b1 || work_a !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_setup: got pend=%b work=%b want 1 1", pend_a, work_a);
        end
        step(0, 0, 0);
        checks++;
        if (act_a !== '0 || act_b !== '0) begin
            failures++;
            $display("FAIL rstmid_forced: got a=%h b=%h want 0", act_a, act_b);
        end
        step(0, 0, 1);
        checks++;
        if (act_a !== '0 || act_b !== '0) begin
            failures++;
            $display("FAIL rstmid_idle: got a=%h b=%h want 0", act_a, act_b);
        end
        step(0, 1, 1);
        checks++;
        if (act_a !== '0 || act_b !== '0) begin
            failures++;
            $display("FAIL rstmid_start_ignored: got a=%h b=%h want 0", act_a, act_b);
        end
        step(0, 0, 1);
        checks++;
        if (work_a !== 1'b0 || work_b !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_work: got a=%b b=%b want 0 0", work_a, work_b);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] got;
        bit p, s, r;
        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            p = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 3) == 0);
            step(p, s, r);
            for (int i = 0; i < 2; i++) begin
                got = (i == 0) ? act_a : act_b;
                checks++;
                if (got !== exp_v[i]) begin
                    failures++;
                    $display("FAIL random inst%0d cycle %0d: got %h want %h", i, cyc, got, exp_v[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_reset_mid_work();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bash_perm_ctrl.md
# bash_perm_ctrl

Parametrised control unit for the bash-f sponge permutation core: sequences the prepare, start and round phases of one permutation per absorbed block. It also exposes a round index for round-constant selection and buffers one start request arriving mid-permutation so blocks can run back-to-back. It sits between the sponge's input/output interface logic, which drives the prep/start requests, and the permutation datapath, which consumes work/round/first.

## Interface
Parameters:
- ROUNDS, 24, total permutation rounds; ROUNDS/RPC must be ≥ 2.
- RPC, 1, rounds unrolled per work cycle; must divide ROUNDS.
- ITER (local), ROUNDS/RPC, number of work cycles per permutation.
- CW (local), $clog2(ITER), width of the iteration counter.
- RW (local), $clog2(ROUNDS), width of round_o.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- prep_active_i  in  1  request: load a fresh state (new message).
- start_active_i  in  1  request: run one permutation on the current state.
- prep_o  out  1  accepted prep request; datapath loads its initial state this cycle.
- start_o  out  1  accepted start request; datapath absorbs its block this cycle.
- first_o  out  1  accompanies start_o for the first block after a prep.
- work_o  out  1  datapath applies RPC rounds this cycle.
- round_o  out  RW  index of the first round applied this cycle; 0 when work_o=0.
- active_o  out  1  permutation in progress (equals work_o).
- rdy_o  out  1  a start request would be accepted or buffered this cycle.
- done_o  out  1  one-cycle pulse, the cycle after a permutation's final work cycle.
- pend_o  out  1  a start request is buffered.

## Operation
- States: IDLE, PREP, START, WORK, WAIT. Counter k (CW bits) and pend flag are registered.
- Mealy outputs are combinational from state and inputs. While rst_ni=0, every output is forced to 0, and state, k, pend and done are cleared; state←IDLE.
- IDLE: rdy_o=prep_active_i. If prep_active_i=1: prep_o=1, →PREP.
- PREP: rdy_o=1.
  - start_active_i=1: start_o=1, first_o=1, →START. Start has priority here.
  - Otherwise prep_o=prep_active_i; re-prep is allowed.
- START: one cycle. work_o=1, round_o=0, k←1, pend←0. If ITER≥2, →WORK.
- WORK: work_o=1, round_o=k·RPC, rdy_o=~pend.
  - prep_active_i=1 (abort): prep_o=1, pend←0, →PREP, no done_o. Abort has priority over start.
  - Otherwise, if start_active_i=1 and pend=0: pend←1. A start request while pend=1 is ignored.
  - If k==ITER-1 and no abort:
    - With pend=1 (including pend set this cycle): start_o=1, first_o=0, →START (back-to-back).
    - Otherwise: →WAIT.
    - In both cases done←1 for one cycle.
  - Otherwise k←k+1.
- WAIT: rdy_o=1. prep_active_i has priority:
  - prep_active_i=1: prep_o=1, →PREP.
  - start_active_i=1: start_o=1, first_o=0, →START.
- done_o is a registered flag set only on a completed final work cycle and cleared the next cycle.
- Any unreachable state encoding → IDLE with all outputs 0.

## Timing
- Start accepted at cycle t (start_o=1): work_o=1 on cycles t+1 … t+ITER.
- round_o on those cycles is 0, RPC, 2·RPC, …, ROUNDS-RPC.
- done_o=1 at t+ITER+1.
- Back-to-back: with pend set, the next start_o coincides with the final work cycle t+ITER. The next permutation's work spans t+ITER+1 … t+2·ITER, with no idle gap, and done_o of the first permutation coincides with the second one's START cycle.
- Abort via prep at any WORK cycle: prep_o the same cycle, PREP the next; work_o drops immediately and done_o never pulses.
- Reset asserted mid-WORK: the next cycle is IDLE with all outputs 0 and the buffered start is discarded.

## Test plan
- ROUNDS=24, RPC=1: prep at cycle 0, start at 2 → first_o=1 at 2; work_o high cycles 3–26; round_o 0…23; done_o at 27; then WAIT with rdy_o=1.
- ROUNDS=24, RPC=4: single start → exactly 6 work cycles with round_o 0,4,8,12,16,20; done_o one cycle after the last.
- Start during WORK (RPC=1, at the 5th work cycle) → pend_o=1, rdy_o=0. At round_o=23 start_o=1, first_o=0; next cycle round_o=0 with no gap; done_o=1 in that same cycle.
- Second start while pend_o=1 → ignored; exactly one extra permutation (24 work cycles) follows.
- prep and start asserted together at round_o=10 → prep_o=1, start_o=0, pend cleared; next cycle PREP, work_o=0, done_o never asserted. Start in PREP then gives first_o=1.
- rst_ni=0 for one cycle mid-WORK with pend_o=1 → all outputs 0; IDLE afterwards; start_active_i alone in IDLE gives no response (rdy_o=0).
